tdoa_capture_sequencer: RTL and testbench
=========================================

# tdoa_capture_sequencer

Front-end controller that sequences the compass direction solver. It watches three microphone onset strobes (A, B, C) and timestamps each first arrival inside a bounded capture window. It then issues one `trigger` pulse with the signed delay pair `dAB`/`dAC`, and holds off re-arming until the solver has finished its update/max-search pass and room echoes have decayed.

## Interface
Parameters:
- `WINDOW`, default 40: max cycles from first onset to last onset; legal range 2..255.
- `HOLDOFF`, default 1000: cycles spent in HOLDOFF after a report or timeout; must be ≥ 18 (solver pass length); legal range 18..65535.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  arms the sequencer when high.
- `onset_a` / `onset_b` / `onset_c`  in  1 each  onset levels, already synchronous to `clk`; only rising edges are used.
- `trigger`  out  1  one-cycle pulse; `dAB`/`dAC` are valid in the same cycle.
- `dAB`  out  6 signed  t_B − t_A in cycles, saturated.
- `dAC`  out  6 signed  t_C − t_A in cycles, saturated.
- `armed`  out  1  high while in ARMED.
- `drop_cnt`  out  8  count of timed-out captures; saturates at 255.

## Operation
- Edge detect: `rise_x = onset_x & ~prev_x`. `prev_x` is registered every cycle and resets to 1, so a level that is already high at reset release is not taken as an edge.
- States: IDLE, ARMED, CAPTURE, REPORT, HOLDOFF.
- IDLE: go to ARMED when `enable` = 1. All rises are ignored.
- ARMED: on any rise, stamp each rising channel with time 0, set its seen flag, and set timer to 1.
  - If all three channels rise together, go to REPORT.
  - Otherwise go to CAPTURE.
- CAPTURE, evaluated each cycle:
  - Each rise on an unseen channel stamps that channel with the current timer value and sets its seen flag.
  - Rises on already-seen channels are ignored.
  - If all three channels are seen after this cycle's stamps, go to REPORT. Completion takes priority over timeout in the same cycle.
  - Else if timer == WINDOW, increment `drop_cnt` (saturating) and go to HOLDOFF with no trigger.
  - Else increment the timer.
- Entry to REPORT: register `dAB` = sat6(t_B − t_A) and `dAC` = sat6(t_C − t_A).
  - Subtraction uses a 10-bit signed intermediate.
  - sat6 clamps to −32..+31.
- REPORT: `trigger` = 1 for exactly this one cycle. Go to HOLDOFF and load the holdoff counter with HOLDOFF − 1.
- HOLDOFF: decrement the counter each cycle; all rises are ignored. At 0, go to ARMED if `enable` = 1, else IDLE.
- `enable` falling in ARMED or CAPTURE: go to IDLE on the next edge. The capture is discarded with no drop count and no trigger.
- `enable` falling in REPORT or HOLDOFF: the current pass completes, then the block goes to IDLE.
- `dAB`/`dAC` hold their last reported value until the next REPORT.
- `trigger` never asserts outside REPORT. Two trigger pulses are always ≥ HOLDOFF + 2 cycles apart.

## Timing
- Reset values: state = IDLE, `trigger` = 0, `dAB` = 0, `dAC` = 0, `armed` = 0, `drop_cnt` = 0, seen flags = 0, `prev_x` = 1.
- Reset is asynchronous: asserting `rst_n` mid-capture or mid-holdoff returns to IDLE immediately, and the partial capture is lost.
- Arming: `armed` goes high on the edge after `enable` is sampled high in IDLE.
- Report latency: if edge N is the first edge that samples the last channel's rising onset, `trigger` is high in cycle N+1 (between edges N and N+1) with `dAB`/`dAC` valid. That is one cycle of latency.
- Timeout: with the first rise sampled at edge F, the block enters HOLDOFF at edge F + WINDOW. It returns to ARMED at edge F + WINDOW + HOLDOFF.
- Re-arm after report: with trigger in cycle R, `armed` is high from cycle R + HOLDOFF + 1 when `enable` = 1.

## Test plan
- Reset/idle: hold `enable` = 0 and pulse all onsets → `trigger` never asserts; `dAB` = `dAC` = 0; `drop_cnt` = 0; `armed` = 0.
- Normal capture: A rises at cycle 100, B at 105, C at 109 → single `trigger` in cycle 110 with `dAB` = +5 and `dAC` = +9. `armed` returns HOLDOFF + 1 cycles later.
- Simultaneous and negative delays:
  - A, B and C rise on the same edge → `trigger` next cycle with `dAB` = 0, `dAC` = 0.
  - Order C, B, A at 0/3/12 → `dAB` = −9, `dAC` = −12.
- Saturation (WINDOW = 80):
  - B rises 50 cycles after A, C at +1 → `dAB` = +31, `dAC` = +1.
  - A rises 40 cycles after B and C → `dAB` = −32, `dAC` = −32.
- Timeout: A and B rise and C never does → no `trigger`; `drop_cnt` = 1 after WINDOW cycles; `armed` is high again after HOLDOFF more cycles.
- Holdoff, abort and reset:
  - Onsets during HOLDOFF produce no trigger.
  - Dropping `enable` mid-CAPTURE → IDLE with no drop count.
  - `rst_n` = 0 mid-CAPTURE → all outputs return to reset values immediately.
  - A level already high at reset release is not treated as an edge.

Source files
------------

// File: rtl/tdoa_capture_sequencer.sv
// Onset capture sequencer: timestamps A/B/C first arrivals in a bounded
// window, reports saturated dAB/dAC with a trigger, then holds off.
module tdoa_capture_sequencer #(
  parameter int WINDOW  = 40,
  parameter int HOLDOFF = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              onset_a,
  input  logic              onset_b,
  input  logic              onset_c,
  output logic              trigger,
  output logic signed [5:0] dAB,
  output logic signed [5:0] dAC,
  output logic              armed,
  output logic [7:0]        drop_cnt
);

  localparam logic [7:0]  LP_WIN  = 8'(WINDOW);
  localparam logic [15:0] LP_HOLD = 16'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPT, S_REPORT, S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_prev;
  logic [2:0]        w_rise;
  logic [2:0]        w_new;
  logic [2:0]        r_seen;
  logic [2:0]        w_seen_nxt;
  logic [7:0]        r_timer;
  logic [7:0]        r_ta, r_tb, r_tc;
  logic [7:0]        w_ta, w_tb, w_tc;
  logic [15:0]       r_hold;
  logic              w_done;
  logic              w_tout;
  logic signed [5:0] r_dab, r_dac;
  logic [7:0]        r_drop;

  function automatic logic signed [5:0] sat6(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic signed [9:0] d;
    d = signed'({2'b00, x}) - signed'({2'b00, y});
    if (d > 10'sd31)
      return 6'h1F;
    else if (d < -10'sd32)
      return 6'h20;
    else
      return d[5:0];
  endfunction

  assign w_rise = {onset_c, onset_b, onset_a} & ~r_prev;
  assign w_new  = w_rise & ~r_seen;

  // stamps and seen flags as they stand after this cycle's rises
  always_comb begin
    w_seen_nxt = r_seen;
    w_ta = r_ta;
    w_tb = r_tb;
    w_tc = r_tc;
    if (r_state == S_ARMED) begin
      w_seen_nxt = w_rise;
      w_ta = 8'd0;
      w_tb = 8'd0;
      w_tc = 8'd0;
    end else if (r_state == S_CAPT) begin
      w_seen_nxt = r_seen | w_rise;
      if (w_new[0]) w_ta = r_timer;
      if (w_new[1]) w_tb = r_timer;
      if (w_new[2]) w_tc = r_timer;
    end
  end

  assign w_done = &w_seen_nxt;
  assign w_tout = (r_timer == LP_WIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (enable) w_next = S_ARMED;
      S_ARMED:
        if (!enable)     w_next = S_IDLE;
        else if (|w_rise) w_next = w_done ? S_REPORT : S_CAPT;
      S_CAPT:
        if (!enable)     w_next = S_IDLE;
        else if (w_done) w_next = S_REPORT;
        else if (w_tout) w_next = S_HOLD;
      S_REPORT:
        w_next = S_HOLD;
      S_HOLD:
        if (r_hold == 16'd0) w_next = enable ? S_ARMED : S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    trigger  = (r_state == S_REPORT);
    armed    = (r_state == S_ARMED);
    dAB      = r_dab;
    dAC      = r_dac;
    drop_cnt = r_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 3'b111;
      r_seen  <= 3'b000;
      r_timer <= 8'd0;
      r_ta    <= 8'd0;
      r_tb    <= 8'd0;
      r_tc    <= 8'd0;
      r_hold  <= 16'd0;
      r_dab   <= 6'sd0;
      r_dac   <= 6'sd0;
      r_drop  <= 8'd0;
    end else begin
      r_prev  <= {onset_c, onset_b, onset_a};
      r_seen  <= (w_next == S_CAPT) ? w_seen_nxt : 3'b000;
      r_timer <= (r_state == S_CAPT) ? r_timer + 8'd1 : 8'd1;
      r_ta    <= w_ta;
      r_tb    <= w_tb;
      r_tc    <= w_tc;
      r_hold  <= (r_state == S_HOLD) ? r_hold - 16'd1 : LP_HOLD;
      if (w_next == S_REPORT) begin
        r_dab <= sat6(w_tb, w_ta);
        r_dac <= sat6(w_tc, w_ta);
      end
      if (r_state == S_CAPT && w_next == S_HOLD && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
    end
  end

endmodule

// File: tb/tb_tdoa_capture_sequencer.sv
// Randomized + directed bench for tdoa_capture_sequencer with an
// event-time reference model compared on every falling edge.
module tb_tdoa_capture_sequencer;

  localparam int W = 80;
  localparam int H = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [2:0]        on = 3'b000;
  logic              trig;
  logic              armed;
  logic signed [5:0] dab;
  logic signed [5:0] dac;
  logic [7:0]        drop;

  tdoa_capture_sequencer #(.WINDOW(W), .HOLDOFF(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (en),
    .onset_a  (on[0]),
    .onset_b  (on[1]),
    .onset_c  (on[2]),
    .trigger  (trig),
    .dAB      (dab),
    .dAC      (dac),
    .armed    (armed),
    .drop_cnt (drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: modes 0 idle,1 armed,2 capture,3 report,4 holdoff
  int         m_mode, m_cyc, m_first, m_end, m_drop, m_dab, m_dac;
  int         m_t[3];
  logic [2:0] m_prev;

  function automatic int sat(input int d);
    if (d > 31) return 31;
    if (d < -32) return -32;
    return d;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_cyc = 0; m_first = 0; m_end = 0;
    m_drop = 0; m_dab = 0; m_dac = 0;
    m_prev = 3'b111;
    m_t = '{-1, -1, -1};
  endtask

  task automatic m_report();
    m_dab = sat(m_t[1] - m_t[0]);
    m_dac = sat(m_t[2] - m_t[0]);
    m_mode = 3;
  endtask

  task automatic m_step();
    logic [2:0] rise;
    m_cyc++;
    rise = on & ~m_prev;
    m_prev = on;
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (!en) m_mode = 0;
        else if (rise != 3'b000) begin
          for (int i = 0; i < 3; i++) m_t[i] = rise[i] ? m_cyc : -1;
          m_first = m_cyc;
          if (rise == 3'b111) m_report();
          else m_mode = 2;
        end
      end
      2: begin
        if (!en) m_mode = 0;
        else begin
          for (int i = 0; i < 3; i++)
            if (rise[i] && m_t[i] < 0) m_t[i] = m_cyc;
          if (m_t[0] >= 0 && m_t[1] >= 0 && m_t[2] >= 0) m_report();
          else if (m_cyc - m_first == W) begin
            if (m_drop < 255) m_drop++;
            m_mode = 4;
            m_end = m_cyc + H;
          end
        end
      end
      3: begin
        m_mode = 4;
        m_end = m_cyc + H;
      end
      default: if (m_cyc == m_end) m_mode = en ? 1 : 0;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("trigger", int'(trig), int'(m_mode == 3));
      chk("armed", int'(armed), int'(m_mode == 1));
      chk("dAB", int'(dab), m_dab);
      chk("dAC", int'(dac), m_dac);
      chk("drop_cnt", int'(drop), m_drop);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hit(input logic [2:0] m);
    on = m;
    @(negedge clk);
    on = 3'b000;
  endtask

  task automatic wait_trig(output int n);
    n = 0;
    while (!trig && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!trig) n = -1;
  endtask

  task automatic wait_armed(output int n);
    n = 0;
    while (!armed && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!armed) n = -1;
  endtask

  initial begin
    int n;
    int cnt;
    #22 rst_n = 1'b1;
    @(negedge clk);
    // disabled: onsets ignored
    hit(3'b111); tick(2); hit(3'b001); tick(3);
    chk("idle_armed", int'(armed), 0);
    chk("idle_dab", int'(dab), 0);
    chk("idle_drop", int'(drop), 0);

    // level high across reset release is not an edge
    on = 3'b001;
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_armed(n);
    tick(5);
    chk("level_no_edge", int'(armed), 1);
    on = 3'b000;
    tick(1);

    // normal capture A/B/C at 0/5/9
    hit(3'b001); tick(4); hit(3'b010); tick(3); hit(3'b100);
    wait_trig(n);
    chk("norm_lat", n, 0);
    chk("norm_dab", int'(dab), 5);
    chk("norm_dac", int'(dac), 9);
    wait_armed(n);
    chk("rearm_lat", n, H + 1);

    // simultaneous
    hit(3'b111);
    wait_trig(n);
    chk("simul_lat", n, 0);
    chk("simul_dab", int'(dab), 0);
    chk("simul_dac", int'(dac), 0);
    wait_armed(n);

    // C, B, A at 0/3/12; then onsets during holdoff
    hit(3'b100); tick(2); hit(3'b010); tick(8); hit(3'b001);
    wait_trig(n);
    chk("neg_dab", int'(dab), -9);
    chk("neg_dac", int'(dac), -12);
    cnt = 0;
    repeat (H) begin
      on = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (trig) cnt++;
    end
    on = 3'b000;
    chk("holdoff_trig", cnt, 0);
    wait_armed(n);

    // positive saturation
    hit(3'b001); hit(3'b100); tick(48); hit(3'b010);
    wait_trig(n);
    chk("satp_dab", int'(dab), 31);
    chk("satp_dac", int'(dac), 1);
    wait_armed(n);

    // negative saturation
    hit(3'b110); tick(39); hit(3'b001);
    wait_trig(n);
    chk("satn_dab", int'(dab), -32);
    chk("satn_dac", int'(dac), -32);
    wait_armed(n);

    // timeout
    hit(3'b011); tick(W - 1);
    chk("tout_before", int'(drop), 0);
    tick(1);
    chk("tout_drop", int'(drop), 1);
    chk("tout_armed", int'(armed), 0);
    tick(H - 1);
    chk("tout_hold", int'(armed), 0);
    tick(1);
    chk("tout_rearm", int'(armed), 1);

    // abort by enable
    hit(3'b001); tick(3);
    en = 1'b0;
    tick(1);
    chk("abort_armed", int'(armed), 0);
    tick(100);
    chk("abort_drop", int'(drop), 1);
    en = 1'b1;
    wait_armed(n);
    chk("abort_rearm", n, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) on = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 3) == 0) on = 3'b000;
      if ($urandom_range(0, 299) == 0) en = ~en;
      @(negedge clk);
    end
    on = 3'b000;
    en = 1'b1;
    tick(1);
    wait_armed(n);
    chk("rand_rearm", int'(n >= 0), 1);

    // asynchronous reset mid-capture
    hit(3'b001); tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trig", int'(trig), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_dab", int'(dab), 0);
    chk("rst_dac", int'(dac), 0);
    chk("rst_drop", int'(drop), 0);
    #4 rst_n = 1'b1;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
